// File: rtl/multi_divclk.sv
// ============================================================================
// Module   : multi_divclk
// Purpose  : N_CH independent programmable clock dividers (pulse/square) with
//            shadowed divisor/mode reloads applied on period boundaries.
//            Optional global phase-align input enabled by MULTI_DIVCLK_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_divclk #(
    parameter int BIT_SZ = 16,
    parameter int N_CH   = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        en,
    input  logic [N_CH-1:0]        mode,
    input  logic [N_CH*BIT_SZ-1:0] k_flat,
    input  logic [N_CH-1:0]        k_load,
    output logic [N_CH-1:0]        clk_out,
    output logic [N_CH-1:0]        done
`ifdef MULTI_DIVCLK_SYNC_EN
    ,
    input  logic                   sync_in
`endif
);

    localparam logic [BIT_SZ-1:0] c_K_RESET = {BIT_SZ{1'b1}};
    localparam logic [BIT_SZ-1:0] c_ONE     = BIT_SZ'(1);

    logic w_sync;

`ifdef MULTI_DIVCLK_SYNC_EN
    assign w_sync = sync_in;
`else
    assign w_sync = 1'b0;
`endif

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [BIT_SZ-1:0] r_count;
        logic [BIT_SZ-1:0] r_k_act;
        logic [BIT_SZ-1:0] r_k_shd;
        logic              r_mode_act;
        logic              r_mode_shd;
        logic              r_pend;
        logic              r_clk_out;
        logic              r_done;

        logic              w_boundary;
        logic              w_idle;
        logic [BIT_SZ-1:0] w_k_eff;
        logic              w_mode_eff;

        // Settings that take effect at this edge if the shadow is pending.
        assign w_k_eff    = r_pend ? r_k_shd    : r_k_act;
        assign w_mode_eff = r_pend ? r_mode_shd : r_mode_act;
        assign w_idle     = w_sync || !en[ch];
        assign w_boundary = en[ch] && (r_count == '0);

        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                r_count    <= '0;
                r_k_act    <= c_K_RESET;
                r_k_shd    <= c_K_RESET;
                r_mode_act <= 1'b0;
                r_mode_shd <= 1'b0;
                r_pend     <= 1'b0;
                r_clk_out  <= 1'b0;
                r_done     <= 1'b0;
            end else begin
                if (w_idle || w_boundary) begin
                    r_k_act    <= w_k_eff;
                    r_mode_act <= w_mode_eff;
                    r_pend     <= 1'b0;
                end

                if (w_idle) begin
                    r_count   <= '0;
                    r_clk_out <= 1'b0;
                    r_done    <= 1'b0;
                end else if (w_boundary) begin
                    r_count   <= w_k_eff;
                    r_clk_out <= w_mode_eff ? ~r_clk_out : 1'b1;
                    r_done    <= 1'b1;
                end else begin
                    r_count   <= r_count - c_ONE;
                    r_clk_out <= r_mode_act ? r_clk_out : 1'b0;
                    r_done    <= 1'b0;
                end

                // A load landing on a boundary re-arms the shadow for the next one.
                if (k_load[ch]) begin
                    r_k_shd    <= k_flat[ch*BIT_SZ +: BIT_SZ];
                    r_mode_shd <= mode[ch];
                    r_pend     <= 1'b1;
                end
            end
        end

        assign clk_out[ch] = r_clk_out;
        assign done[ch]    = r_done;
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_divclk.sv
// ============================================================================
// Module   : tb_multi_divclk
// Purpose  : Directed, table-driven self-checking bench for multi_divclk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_divclk;

    localparam int BIT_SZ = 16;
    localparam int N_CH   = 4;
    localparam int N_VEC  = 36;

    logic                   clk_in;
    logic                   rst_n;
    logic [N_CH-1:0]        en;
    logic [N_CH-1:0]        mode;
    logic [N_CH*BIT_SZ-1:0] k_flat;
    logic [N_CH-1:0]        k_load;
    logic [N_CH-1:0]        clk_out;
    logic [N_CH-1:0]        done;
`ifdef MULTI_DIVCLK_SYNC_EN
    logic                   sync_in;
`endif

    multi_divclk #(
        .BIT_SZ (BIT_SZ),
        .N_CH   (N_CH)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .k_flat  (k_flat),
        .k_load  (k_load),
        .clk_out (clk_out),
        .done    (done)
`ifdef MULTI_DIVCLK_SYNC_EN
        ,
        .sync_in (sync_in)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  mode;
        logic [3:0]  ld;
        logic [63:0] k;
        logic [3:0]  exp_clk;
        logic [3:0]  exp_done;
    } vec_t;

    vec_t tbl [N_VEC];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(input logic [3:0] en_v, input logic [3:0] mode_v,
                                input logic [3:0] ld_v,
                                input logic [15:0] k3, input logic [15:0] k2,
                                input logic [15:0] k1, input logic [15:0] k0,
                                input logic [3:0] ec, input logic [3:0] ed);
        vec_t v;
        v.en       = en_v;
        v.mode     = mode_v;
        v.ld       = ld_v;
        v.k        = {k3, k2, k1, k0};
        v.exp_clk  = ec;
        v.exp_done = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        // ch0 pulse k=3, ch1 square k=2, ch2 pulse k=0; then ch0 reload k=7
        // mid-period, ch2 switched to square, ch2 disabled/re-enabled, ch3
        // loaded while disabled (shadow applied immediately).
        tbl[0]  = mk(4'b0000, 4'b0010, 4'b0111, 16'd0, 16'd0, 16'd2, 16'd3, 4'b0000, 4'b0000);
        tbl[1]  = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0111, 4'b0111);
        tbl[2]  = mk(4'b0111, 4'b1111, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0110, 4'b0100);
        tbl[3]  = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0110, 4'b0100);
        tbl[4]  = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0100, 4'b0110);
        tbl[5]  = mk(4'b0111, 4'b1010, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0101, 4'b0101);
        tbl[6]  = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0100, 4'b0100);
        tbl[7]  = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0110, 4'b0110);
        tbl[8]  = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0110, 4'b0100);
        tbl[9]  = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0111, 4'b0101);
        tbl[10] = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0100, 4'b0110);
        tbl[11] = mk(4'b0111, 4'b0000, 4'b0001, 16'd0, 16'd0, 16'd0, 16'd7, 4'b0100, 4'b0100);
        tbl[12] = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0100, 4'b0100);
        tbl[13] = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0111, 4'b0111);
        tbl[14] = mk(4'b0111, 4'b1111, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0110, 4'b0100);
        tbl[15] = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0110, 4'b0100);
        tbl[16] = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0100, 4'b0110);
        tbl[17] = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0100, 4'b0100);
        tbl[18] = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0100, 4'b0100);
        tbl[19] = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0110, 4'b0110);
        tbl[20] = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0110, 4'b0100);
        tbl[21] = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0111, 4'b0101);
        tbl[22] = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0100, 4'b0110);
        tbl[23] = mk(4'b0111, 4'b0100, 4'b0100, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0100, 4'b0100);
        tbl[24] = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0000, 4'b0100);
        tbl[25] = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0110, 4'b0110);
        tbl[26] = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0010, 4'b0100);
        tbl[27] = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0110, 4'b0100);
        tbl[28] = mk(4'b0011, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0000, 4'b0010);
        tbl[29] = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0101, 4'b0101);
        tbl[30] = mk(4'b0111, 4'b1000, 4'b1000, 16'd1, 16'd0, 16'd0, 16'd0, 4'b0000, 4'b0100);
        tbl[31] = mk(4'b0111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0110, 4'b0110);
        tbl[32] = mk(4'b1111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b1010, 4'b1100);
        tbl[33] = mk(4'b1111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b1110, 4'b0100);
        tbl[34] = mk(4'b1111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0000, 4'b1110);
        tbl[35] = mk(4'b1111, 4'b0000, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0100, 4'b0100);

        rst_n  = 1'b0;
        en     = '0;
        mode   = '0;
        k_flat = '0;
        k_load = '0;
`ifdef MULTI_DIVCLK_SYNC_EN
        sync_in = 1'b0;
`endif
        tick();
        tick();
        chk("reset_clk_out", clk_out, 4'b0000);
        chk("reset_done", done, 4'b0000);
        rst_n = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            en     = tbl[i].en;
            mode   = tbl[i].mode;
            k_load = tbl[i].ld;
            k_flat = tbl[i].k;
            tick();
            chk($sformatf("vec%0d_clk_out", i), clk_out, tbl[i].exp_clk);
            chk($sformatf("vec%0d_done", i), done, tbl[i].exp_done);
        end

        // Pending reload on ch0 lost by an asynchronous reset mid-period.
        en     = 4'b1111;
        mode   = 4'b0000;
        k_load = 4'b0001;
        k_flat = {16'd0, 16'd0, 16'd0, 16'd2};
        tick();
        k_load = 4'b0000;
        chk("preload_clk_out", clk_out, 4'b1000);
        chk("preload_done", done, 4'b1100);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_clk_out", clk_out, 4'b0000);
        chk("async_rst_done", done, 4'b0000);
        en    = 4'b0001;
        rst_n = 1'b1;
        tick();
        chk("post_rst_first_clk_out", clk_out, 4'b0001);
        chk("post_rst_first_done", done, 4'b0001);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("post_rst_kffff_done%0d", i), done, 4'b0000);
        end

`ifdef MULTI_DIVCLK_SYNC_EN
        // ch0 k=3 and ch1 k=5 running out of phase, then phase-aligned.
        rst_n = 1'b0;
        en    = 4'b0000;
        tick();
        rst_n  = 1'b1;
        k_load = 4'b0011;
        k_flat = {16'd0, 16'd0, 16'd5, 16'd3};
        tick();
        k_load = 4'b0000;
        en     = 4'b0001;
        tick();
        tick();
        tick();
        en = 4'b0011;
        tick();
        chk("sync_pre_done", done, 4'b0010);
        tick();
        tick();
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        chk("sync_edge_clk_out", clk_out, 4'b0000);
        chk("sync_edge_done", done, 4'b0000);
        tick();
        chk("sync_align_done", done, 4'b0011);
        chk("sync_align_clk_out", clk_out, 4'b0011);
        tick();
        tick();
        tick();
        tick();
        chk("sync_ch0_next_done", done, 4'b0001);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multi_divclk.md
MULTI_DIVCLK -- requirements
Module: multi_divclk

Interface
REQ-001 Parameter BIT_SZ, default 16, divisor/counter width per channel.
REQ-002 Parameter N_CH, default 4, number of independent divider channels.
REQ-003 Port clk_in  input  1  sole clock; all state updates on posedge clk_in.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port en  input  N_CH  per-channel enable, level.
REQ-006 Port mode  input  N_CH  per-channel mode request: 0 = pulse, 1 = square.
REQ-007 Port k_flat  input  N_CH*BIT_SZ  divisor bus; channel i uses bits [i*BIT_SZ +: BIT_SZ].
REQ-008 Port k_load  input  N_CH  per-channel one-cycle strobe that captures k_flat slice and mode bit.
REQ-009 Port clk_out  output  N_CH  registered divided output per channel.
REQ-010 Port done  output  N_CH  registered one-cycle period-boundary pulse per channel.
REQ-011 Port sync_in  input  1  global phase-align strobe; present only with MULTI_DIVCLK_SYNC_EN.

Function (per channel i, independent)
REQ-012 State: count[BIT_SZ], k_act, mode_act, k_shd, mode_shd, pend flag.
REQ-013 k_load[i]=1 -> k_shd<=slice, mode_shd<=mode[i], pend<=1 at same edge.
REQ-014 Boundary = en[i]=1 and count==0 at a clock edge.
REQ-015 At boundary with pend=1: k_act<=k_shd, mode_act<=mode_shd, pend<=0, count<=k_shd; pre-edge shadow values are used.
REQ-016 k_load coinciding with boundary: shadow takes new value, pend stays 1, new value applies at next boundary.
REQ-017 At boundary with pend=0: count<=k_act.
REQ-018 en=1, count!=0: count<=count-1, wrap impossible.
REQ-019 Pulse mode: clk_out<=1 at boundary, else 0; period k_act+1 cycles, high 1 cycle.
REQ-020 Square mode: clk_out toggles at each boundary, else holds; period 2*(k_act+1), 50% duty.
REQ-021 k_act=0: pulse mode clk_out constant 1; square mode clk_out = clk_in/2.
REQ-022 done<=1 exactly at boundary edges, else 0, both modes.
REQ-023 en=0: count<=0, clk_out<=0, done<=0; pend=1 applies shadows immediately and clears pend.
REQ-024 en 0->1: first enabled edge is a boundary (count==0), clk_out/done high after that edge.
REQ-025 Mode change only via k_load; mode input ignored otherwise.

Reset
REQ-026 rst_n=0 asynchronously: count=0, clk_out=0, done=0, pend=0, mode_act=mode_shd=0, k_act=k_shd=all-ones.
REQ-027 Reset mid-period discards pending load; release takes effect at first posedge with rst_n=1.

Configuration
REQ-028 Macro MULTI_DIVCLK_SYNC_EN defined: port sync_in exists; sync_in=1 forces every channel count<=0, clk_out<=0, done<=0, pend applied, overriding REQ-015..REQ-023 that edge.
REQ-029 Macro undefined: no sync_in port; behaviour identical to sync_in tied 0.

Verification
REQ-030 BIT_SZ=16, ch0 k=3 pulse, en=1 -> clk_out[0] high 1 cycle every 4, done[0] identical.
REQ-031 ch1 k=2 square -> clk_out[1] 3 high/3 low, done[1] at each toggle.
REQ-032 ch0 running k=3, k_load k=7 mid-period -> current 4-cycle period completes, then 8-cycle periods; no short/glitched period.
REQ-033 ch2 k=0 pulse -> clk_out[2] constant 1; switch to square via k_load -> toggles every cycle after next boundary.
REQ-034 rst_n low mid-count with pending load -> outputs 0 immediately, k_act=16'hFFFF after release, load lost.
REQ-035 MULTI_DIVCLK_SYNC_EN: ch0 k=3, ch1 k=5 offset phases, sync_in pulse -> both boundaries on next edge, done[0],done[1] coincide.
